clock_ctrl: RTL and testbench

Front-panel clock controller for the CPU. Debounces the Run/Stop, Step and Speed buttons, runs a run/stop/halt state machine, and drives the CPU clock. It produces a one-cycle clock-enable pulse per CPU cycle plus a matching visual square wave. It sits between the board buttons and the CPU core, and replaces any directly button-driven or derived clock.

---
 rtl/clock_pkg.sv | 36 +++
 rtl/clock_ctrl_btn_debounce.sv | 52 +++++
 rtl/clock_ctrl.sv | 138 +++++++++++++
 tb/tb_clock_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the front-panel clock controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef logic [1:0] speed_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_DIV0            = 25000000;
    localparam int unsigned DEF_DIV1            = 2500000;
    localparam int unsigned DEF_DIV2            = 250000;
    localparam int unsigned DEF_DIV3            = 25000;

    function automatic logic [31:0] div_for_speed(
        input speed_t      speed,
        input logic [31:0] div0,
        input logic [31:0] div1,
        input logic [31:0] div2,
        input logic [31:0] div3
    );
        logic [31:0] div;
        div = div0;
        case (speed)
            2'd1:    div = div1;
            2'd2:    div = div2;
            2'd3:    div = div3;
            default: div = div0;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and one-cycle press pulse
// on each accepted rising level.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_press;
    logic [31:0] r_cnt;
    logic        w_diff;
    logic        w_expire;

    assign w_diff   = (r_sync2 != r_level);
    assign w_expire = w_diff && (r_cnt == DEBOUNCE_CYCLES - 1);

    // Any cycle where the synchronized input agrees with the accepted level restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_expire && r_sync2;
            if (!w_diff) begin
                r_cnt <= 32'd0;
            end else if (w_expire) begin
                r_cnt   <= 32'd0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/clock_ctrl.sv
// Front-panel CPU clock controller: run/stop/halt sequencing, single-step and
// selectable-rate clock enable with a matching visual clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_STOP | idle; step press issues one enable, cpu_clk_o mirrors step button
// ST_RUN  | free-running; one enable per latched divisor period
// ST_HALT | CPU executed HLT; everything frozen until reset
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DIV0            = DEF_DIV0,
    parameter int unsigned DIV1            = DEF_DIV1,
    parameter int unsigned DIV2            = DEF_DIV2,
    parameter int unsigned DIV3            = DEF_DIV3
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       btn_run_i,
    input  logic       btn_step_i,
    input  logic       btn_speed_i,
    input  logic       halt_i,
    output logic       cpu_clk_en_o,
    output logic       cpu_clk_o,
    output logic       running_o,
    output logic       halted_o,
    output logic [1:0] speed_o
);

    logic        w_run_press,  w_step_press,  w_speed_press;
    logic        w_run_level,  w_step_level,  w_speed_level;
    logic [1:0]  w_unused_levels;

    state_t      r_state,   w_state_nxt;
    logic [31:0] r_cnt,     w_cnt_nxt;
    logic [31:0] r_div,     w_div_nxt;
    logic        r_started, w_started_nxt;
    logic        r_en,      w_en_nxt;
    speed_t      r_speed,   w_speed_nxt;
    logic        w_clk;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk_i(clk_i), .rst(rst), .i_btn(btn_run_i),
        .o_level(w_run_level), .o_press(w_run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk_i(clk_i), .rst(rst), .i_btn(btn_step_i),
        .o_level(w_step_level), .o_press(w_step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk_i(clk_i), .rst(rst), .i_btn(btn_speed_i),
        .o_level(w_speed_level), .o_press(w_speed_press)
    );

    assign w_unused_levels = {w_run_level, w_speed_level};

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state   <= ST_STOP;
            r_cnt     <= 32'd0;
            r_div     <= 32'd0;
            r_started <= 1'b0;
            r_en      <= 1'b0;
            r_speed   <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_started <= w_started_nxt;
            r_en      <= w_en_nxt;
            r_speed   <= w_speed_nxt;
        end
    end

    // r_started keeps cpu_clk_o low until the first enable of a run.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_started_nxt = r_started;
        w_en_nxt      = 1'b0;
        w_speed_nxt   = w_speed_press ? r_speed + 2'd1 : r_speed;
        case (r_state)
            ST_STOP: begin
                if (halt_i) begin
                    w_state_nxt = ST_HALT;
                end else if (w_run_press) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = 32'd0;
                    w_div_nxt     = div_for_speed(r_speed, DIV0, DIV1, DIV2, DIV3);
                    w_started_nxt = 1'b0;
                end else if (w_step_press) begin
                    w_en_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_i || w_run_press) begin
                    w_state_nxt   = halt_i ? ST_HALT : ST_STOP;
                    w_cnt_nxt     = 32'd0;
                    w_started_nxt = 1'b0;
                end else if (r_cnt == r_div - 32'd1) begin
                    w_cnt_nxt     = 32'd0;
                    w_div_nxt     = div_for_speed(r_speed, DIV0, DIV1, DIV2, DIV3);
                    w_started_nxt = 1'b1;
                    w_en_nxt      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    always_comb begin
        w_clk = 1'b0;
        case (r_state)
            ST_STOP: w_clk = w_step_level;
            ST_RUN:  w_clk = r_started && (r_cnt < (r_div >> 1));
            default: w_clk = 1'b0;
        endcase
    end

    // halt_i is synchronous, so gating here blocks an enable in the very cycle HLT appears.
    assign cpu_clk_en_o = r_en && !halt_i;
    assign cpu_clk_o    = w_clk;
    assign running_o    = (r_state == ST_RUN);
    assign halted_o     = (r_state == ST_HALT);
    assign speed_o      = r_speed;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with short debounce and divisors (4; 8/6/4/2).
module tb_clock_ctrl;

    logic       clk_i       = 1'b0;
    logic       rst         = 1'b1;
    logic       btn_run_i   = 1'b0;
    logic       btn_step_i  = 1'b0;
    logic       btn_speed_i = 1'b0;
    logic       halt_i      = 1'b0;
    logic       cpu_clk_en_o;
    logic       cpu_clk_o;
    logic       running_o;
    logic       halted_o;
    logic [1:0] speed_o;

    int n_pass  = 0;
    int n_total = 0;

    clock_ctrl #(
        .DEBOUNCE_CYCLES(4), .DIV0(8), .DIV1(6), .DIV2(4), .DIV3(2)
    ) dut (
        .clk_i(clk_i), .rst(rst),
        .btn_run_i(btn_run_i), .btn_step_i(btn_step_i), .btn_speed_i(btn_speed_i),
        .halt_i(halt_i),
        .cpu_clk_en_o(cpu_clk_en_o), .cpu_clk_o(cpu_clk_o),
        .running_o(running_o), .halted_o(halted_o), .speed_o(speed_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        btn_run_i = 1'b0; btn_step_i = 1'b0; btn_speed_i = 1'b0; halt_i = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (cpu_clk_en_o !== 1'b0) $display("FAIL reset_en got %b exp 0", cpu_clk_en_o); else n_pass++;
        n_total++; if (cpu_clk_o !== 1'b0) $display("FAIL reset_clk got %b exp 0", cpu_clk_o); else n_pass++;
        n_total++; if (running_o !== 1'b0) $display("FAIL reset_running got %b exp 0", running_o); else n_pass++;
        n_total++; if (halted_o !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted_o); else n_pass++;
        n_total++; if (speed_o !== 2'd0) $display("FAIL reset_speed got %0d exp 0", speed_o); else n_pass++;
    endtask

    // Run pressed at k=0 -> RUN at k=7, enables at k=15,23,31; clk high 4 of 8.
    task automatic test_run();
        logic exp_run, exp_en, exp_clk;
        do_reset();
        btn_run_i = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            exp_run = (k >= 7);
            exp_en  = (k >= 15) && (((k - 7) % 8) == 0);
            exp_clk = (k >= 15) && (((k - 7) % 8) < 4);
            n_total++; if (running_o !== exp_run) $display("FAIL run_running k=%0d got %b exp %b", k, running_o, exp_run); else n_pass++;
            n_total++; if (cpu_clk_en_o !== exp_en) $display("FAIL run_en k=%0d got %b exp %b", k, cpu_clk_en_o, exp_en); else n_pass++;
            n_total++; if (cpu_clk_o !== exp_clk) $display("FAIL run_clk k=%0d got %b exp %b", k, cpu_clk_o, exp_clk); else n_pass++;
            if (k == 10) btn_run_i = 1'b0;
        end
    endtask

    // Each step press: level high k=6..11, enable only at k=7.
    task automatic test_step();
        logic exp_clk;
        int   en_count;
        do_reset();
        en_count = 0;
        for (int p = 0; p < 3; p++) begin
            btn_step_i = 1'b1;
            for (int k = 1; k <= 14; k++) begin
                tick();
                exp_clk = (k >= 6) && (k <= 11);
                if (cpu_clk_en_o === 1'b1) en_count++;
                n_total++; if (cpu_clk_en_o !== (k == 7)) $display("FAIL step_en p=%0d k=%0d got %b exp %b", p, k, cpu_clk_en_o, (k == 7)); else n_pass++;
                n_total++; if (cpu_clk_o !== exp_clk) $display("FAIL step_clk p=%0d k=%0d got %b exp %b", p, k, cpu_clk_o, exp_clk); else n_pass++;
                n_total++; if (running_o !== 1'b0) $display("FAIL step_running p=%0d k=%0d got %b exp 0", p, k, running_o); else n_pass++;
                if (k == 6) btn_step_i = 1'b0;
            end
        end
        n_total++; if (en_count != 3) $display("FAIL step_count got %0d exp 3", en_count); else n_pass++;
    endtask

    task automatic test_bounce();
        do_reset();
        btn_run_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_total++; if (running_o !== 1'b0) $display("FAIL bounce_running k=%0d got %b exp 0", k, running_o); else n_pass++;
            btn_run_i = (k < 8) && ((k % 4) < 2);
        end
        btn_run_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_total++; if (running_o !== (k >= 7)) $display("FAIL clean_running k=%0d got %b exp %b", k, running_o, (k >= 7)); else n_pass++;
            if (k == 6) btn_run_i = 1'b0;
        end
    endtask

    // Speed press k=9..14 lands in period 2; period 2 stays 8, period 3 onward is 6.
    task automatic test_speed();
        logic exp_en;
        do_reset();
        btn_run_i = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            exp_en = (k == 15) || (k == 23) || (k == 29) || (k == 35);
            n_total++; if (cpu_clk_en_o !== exp_en) $display("FAIL speed_en k=%0d got %b exp %b", k, cpu_clk_en_o, exp_en); else n_pass++;
            if (k == 15) begin
                n_total++; if (speed_o !== 2'd0) $display("FAIL speed_before got %0d exp 0", speed_o); else n_pass++;
            end
            if (k == 16) begin
                n_total++; if (speed_o !== 2'd1) $display("FAIL speed_after got %0d exp 1", speed_o); else n_pass++;
            end
            if (k >= 23 && k <= 28) begin
                n_total++; if (cpu_clk_o !== (k <= 25)) $display("FAIL speed_clk k=%0d got %b exp %b", k, cpu_clk_o, (k <= 25)); else n_pass++;
            end
            btn_run_i   = (k < 6);
            btn_speed_i = (k >= 9) && (k < 15);
        end
    endtask

    task automatic test_speed_wrap();
        logic [1:0] exp_speed;
        do_reset();
        exp_speed = 2'd0;
        for (int p = 1; p <= 4; p++) begin
            btn_speed_i = 1'b1;
            repeat (6) tick();
            btn_speed_i = 1'b0;
            repeat (8) tick();
            exp_speed = exp_speed + 2'd1;
            n_total++; if (speed_o !== exp_speed) $display("FAIL wrap_speed p=%0d got %0d exp %0d", p, speed_o, exp_speed); else n_pass++;
        end
        n_total++; if (running_o !== 1'b0) $display("FAIL wrap_running got %b exp 0", running_o); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        btn_run_i = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6) btn_run_i = 1'b0;
        end
        tick();
        halt_i = 1'b1;
        #1;
        n_total++; if (cpu_clk_en_o !== 1'b0) $display("FAIL halt_en_blocked got %b exp 0", cpu_clk_en_o); else n_pass++;
        n_total++; if (running_o !== 1'b1) $display("FAIL halt_running_before got %b exp 1", running_o); else n_pass++;
        n_total++; if (halted_o !== 1'b0) $display("FAIL halt_halted_before got %b exp 0", halted_o); else n_pass++;
        tick();
        n_total++; if (halted_o !== 1'b1) $display("FAIL halt_halted got %b exp 1", halted_o); else n_pass++;
        n_total++; if (running_o !== 1'b0) $display("FAIL halt_running got %b exp 0", running_o); else n_pass++;
        halt_i     = 1'b0;
        btn_run_i  = 1'b1;
        btn_step_i = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_total++; if (halted_o !== 1'b1) $display("FAIL halt_hold k=%0d got %b exp 1", k, halted_o); else n_pass++;
            n_total++; if (cpu_clk_en_o !== 1'b0) $display("FAIL halt_en k=%0d got %b exp 0", k, cpu_clk_en_o); else n_pass++;
            n_total++; if (cpu_clk_o !== 1'b0) $display("FAIL halt_clk k=%0d got %b exp 0", k, cpu_clk_o); else n_pass++;
            if (k == 6) begin
                btn_run_i  = 1'b0;
                btn_step_i = 1'b0;
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (halted_o !== 1'b0) $display("FAIL halt_rst_halted got %b exp 0", halted_o); else n_pass++;
        n_total++; if (running_o !== 1'b0) $display("FAIL halt_rst_running got %b exp 0", running_o); else n_pass++;
    endtask

    task automatic test_run_step_same();
        do_reset();
        btn_run_i  = 1'b1;
        btn_step_i = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_total++; if (cpu_clk_en_o !== 1'b0) $display("FAIL same_en k=%0d got %b exp 0", k, cpu_clk_en_o); else n_pass++;
            n_total++; if (running_o !== (k >= 7)) $display("FAIL same_running k=%0d got %b exp %b", k, running_o, (k >= 7)); else n_pass++;
            if (k == 6) begin
                btn_run_i  = 1'b0;
                btn_step_i = 1'b0;
            end
        end
    endtask

    // Reset on the edge that would launch the step enable must cancel it.
    task automatic test_reset_cancel();
        do_reset();
        btn_step_i = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        n_total++; if (cpu_clk_o !== 1'b1) $display("FAIL cancel_level got %b exp 1", cpu_clk_o); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (cpu_clk_en_o !== 1'b0) $display("FAIL cancel_en got %b exp 0", cpu_clk_en_o); else n_pass++;
        n_total++; if (cpu_clk_o !== 1'b0) $display("FAIL cancel_clk got %b exp 0", cpu_clk_o); else n_pass++;
        rst        = 1'b0;
        btn_step_i = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_bounce();
        test_speed();
        test_speed_wrap();
        test_halt();
        test_run_step_same();
        test_reset_cancel();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
